// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: highest-stage-wins stall merge, registered redirect, refill blanking, stall watchdog.
// Optional perf counters enabled by defining CTRL_PERF_EN.
module pipe_ctrl #(
  parameter int STAGES     = 6,
  parameter int PC_W       = 32,
  parameter int REFILL_CYC = 2,
  parameter int WDOG_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] stall_req,
  input  logic              flush_req,
  input  logic [PC_W-1:0]   flush_pc,
  output logic [STAGES-1:0] stall,
  output logic              flush,
  output logic [PC_W-1:0]   new_pc,
  output logic              refill,
  output logic              stall_timeout
`ifdef CTRL_PERF_EN
  ,
  output logic [31:0]       perf_stall_cyc,
  output logic [31:0]       perf_flush_cnt
`endif
);

  localparam int RC_W = (REFILL_CYC > 1) ? $clog2(REFILL_CYC) : 1;
  localparam logic [RC_W-1:0] RC_LOAD = RC_W'(REFILL_CYC - 1);
  localparam logic [WDOG_W-1:0] WD_MAX = '1;

  typedef enum logic [1:0] {IDLE, FLUSH, REFILL} state_t;

  state_t            state;
  logic [RC_W-1:0]   rc_cnt;
  logic [WDOG_W-1:0] wd_cnt;
  logic [STAGES-1:0] merged;
  logic              stall_any;

  // Suffix-OR from the top: every stage at or below the highest requester is held.
  always_comb begin
    merged = '0;
    merged[STAGES-1] = stall_req[STAGES-1];
    for (int i = STAGES - 2; i >= 1; i--) begin
      merged[i] = merged[i+1] | stall_req[i];
    end
    merged[0] = merged[1];
  end

  assign stall     = (rst && state == IDLE) ? merged : '0;
  assign stall_any = |stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      flush  <= 1'b0;
      refill <= 1'b0;
      new_pc <= '0;
      rc_cnt <= '0;
    end else if (flush_req) begin
      // A new redirect always wins, even mid-flush or mid-refill.
      state  <= FLUSH;
      flush  <= 1'b1;
      refill <= 1'b0;
      new_pc <= flush_pc;
      rc_cnt <= '0;
    end else begin
      case (state)
        FLUSH: begin
          state  <= REFILL;
          flush  <= 1'b0;
          refill <= 1'b1;
          rc_cnt <= RC_LOAD;
        end
        REFILL: begin
          if (rc_cnt == '0) begin
            state  <= IDLE;
            refill <= 1'b0;
          end else begin
            rc_cnt <= rc_cnt - 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          flush  <= 1'b0;
          refill <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt        <= '0;
      stall_timeout <= 1'b0;
    end else if (stall_any) begin
      if (wd_cnt != WD_MAX) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
      if (wd_cnt >= WD_MAX - 1'b1) begin
        stall_timeout <= 1'b1;
      end
    end else begin
      wd_cnt <= '0;
    end
  end

`ifdef CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_cyc <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall_any && perf_stall_cyc != 32'hFFFF_FFFF) begin
        perf_stall_cyc <= perf_stall_cyc + 32'd1;
      end
      if (flush && perf_flush_cnt != 32'hFFFF_FFFF) begin
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: merge vector table, hand-written flush/watchdog/reset sequences, random run against a model.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall_req;
  logic        flush_req;
  logic [31:0] flush_pc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        refill;
  logic        stall_timeout;
`ifdef CTRL_PERF_EN
  logic [31:0] perf_stall_cyc;
  logic [31:0] perf_flush_cnt;
`endif

  pipe_ctrl #(.STAGES(6), .PC_W(32), .REFILL_CYC(2), .WDOG_W(8)) dut (
    .clk(clk), .rst(rst), .stall_req(stall_req), .flush_req(flush_req), .flush_pc(flush_pc),
    .stall(stall), .flush(flush), .new_pc(new_pc), .refill(refill), .stall_timeout(stall_timeout)
`ifdef CTRL_PERF_EN
    , .perf_stall_cyc(perf_stall_cyc), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a flush flag, a count of refill cycles still to come, and plain integer counters.
  bit          m_flush;
  logic [31:0] m_pc;
  int          m_refill_left;
  int          m_wd;
  bit          m_to;
  longint      m_pstall;
  longint      m_pflush;

  typedef struct {
    logic [5:0] req;
    logic [5:0] exp;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] merge_ref(input logic [5:0] r);
    int k = -1;
    for (int i = 1; i < 6; i++) if (r[i]) k = i;
    if (k < 0) return 6'd0;
    return 6'((1 << (k + 1)) - 1);
  endfunction

  function automatic logic [5:0] exp_stall();
    if (m_flush || m_refill_left > 0) return 6'd0;
    return merge_ref(stall_req);
  endfunction

  task automatic model_reset();
    m_flush = 0; m_pc = '0; m_refill_left = 0; m_wd = 0; m_to = 0; m_pstall = 0; m_pflush = 0;
  endtask

  task automatic model_step(input logic [5:0] es, input logic fr, input logic [31:0] pc);
    if (es != 0) begin
      m_wd = (m_wd < 255) ? m_wd + 1 : 255;
      if (m_pstall < 64'hFFFF_FFFF) m_pstall++;
    end else begin
      m_wd = 0;
    end
    if (m_wd == 255) m_to = 1;
    if (m_flush && m_pflush < 64'hFFFF_FFFF) m_pflush++;
    if (fr) begin
      m_flush = 1; m_pc = pc; m_refill_left = 0;
    end else if (m_flush) begin
      m_flush = 0; m_refill_left = 2;
    end else if (m_refill_left > 0) begin
      m_refill_left--;
    end
  endtask

  task automatic check_all();
    chk("stall", 64'(stall), 64'(exp_stall()));
    chk("flush", 64'(flush), 64'(m_flush));
    if (m_flush) chk("new_pc", 64'(new_pc), 64'(m_pc));
    chk("refill", 64'(refill), 64'(m_refill_left > 0));
    chk("stall_timeout", 64'(stall_timeout), 64'(m_to));
`ifdef CTRL_PERF_EN
    chk("perf_stall_cyc", 64'(perf_stall_cyc), 64'(m_pstall));
    chk("perf_flush_cnt", 64'(perf_flush_cnt), 64'(m_pflush));
`endif
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic cyc(input logic [5:0] sr, input logic fr, input logic [31:0] pc);
    logic [5:0] es;
    stall_req = sr; flush_req = fr; flush_pc = pc;
    #1;
    check_all();
    es = exp_stall();
    @(posedge clk);
    model_step(es, fr, pc);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    tbl[0] = '{6'b000000, 6'b000000};
    tbl[1] = '{6'b000001, 6'b000000};
    tbl[2] = '{6'b001000, 6'b001111};
    tbl[3] = '{6'b001100, 6'b001111};
    tbl[4] = '{6'b000100, 6'b000111};
    tbl[5] = '{6'b000010, 6'b000011};
    tbl[6] = '{6'b100000, 6'b111111};
    tbl[7] = '{6'b010101, 6'b011111};

    rst = 1'b0; stall_req = 6'b001000; flush_req = 1'b0; flush_pc = 32'h0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_flush", 64'(flush), 64'd0);
    chk("rst_new_pc", 64'(new_pc), 64'd0);
    chk("rst_refill", 64'(refill), 64'd0);
    chk("rst_timeout", 64'(stall_timeout), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();

    repeat (10) cyc(6'b0, 1'b0, 32'h0);

    // Merge table
    for (int i = 0; i < 8; i++) begin
      stall_req = tbl[i].req;
      #1;
      chk("merge_tbl", 64'(stall), 64'(tbl[i].exp));
      cyc(tbl[i].req, 1'b0, 32'h0);
    end
    cyc(6'b0, 1'b0, 32'h0);
    chk("merge_release", 64'(stall), 64'd0);

    // Single flush with refill blanking
    cyc(6'b0, 1'b1, 32'h0000_4000);
    chk("fl_flush_t1", 64'(flush), 64'd1);
    chk("fl_pc_t1", 64'(new_pc), 64'h4000);
    cyc(6'b0, 1'b0, 32'h0);
    stall_req = 6'b001000;
    #1;
    chk("fl_stall_blank_t2", 64'(stall), 64'd0);
    chk("fl_refill_t2", 64'(refill), 64'd1);
    chk("fl_flush_t2", 64'(flush), 64'd0);
    cyc(6'b001000, 1'b0, 32'h0);
    chk("fl_refill_t3", 64'(refill), 64'd1);
    cyc(6'b0, 1'b0, 32'h0);
    chk("fl_refill_t4", 64'(refill), 64'd0);
    stall_req = 6'b001000;
    #1;
    chk("fl_stall_idle_t4", 64'(stall), 64'h0F);
    cyc(6'b001000, 1'b0, 32'h0);

    // Simultaneous stall and flush request in IDLE
    stall_req = 6'b000100; flush_req = 1'b1; flush_pc = 32'h88;
    #1;
    chk("sim_stall", 64'(stall), 64'h07);
    cyc(6'b000100, 1'b1, 32'h88);
    chk("sim_flush", 64'(flush), 64'd1);
    chk("sim_stall_next", 64'(stall), 64'd0);

    // Back-to-back flushes: latest PC wins
    cyc(6'b0, 1'b1, 32'h100);
    chk("b2b_pc1", 64'(new_pc), 64'h100);
    cyc(6'b0, 1'b1, 32'h200);
    chk("b2b_flush2", 64'(flush), 64'd1);
    chk("b2b_pc2", 64'(new_pc), 64'h200);
    cyc(6'b0, 1'b0, 32'h0);
    chk("b2b_flush_off", 64'(flush), 64'd0);
    chk("b2b_refill", 64'(refill), 64'd1);
    repeat (3) cyc(6'b0, 1'b0, 32'h0);

    // Watchdog saturation and stickiness
    do_reset();
    repeat (254) cyc(6'b000100, 1'b0, 32'h0);
    chk("wd_before", 64'(stall_timeout), 64'd0);
    cyc(6'b000100, 1'b0, 32'h0);
    chk("wd_hit", 64'(stall_timeout), 64'd1);
    chk("wd_no_break", 64'(stall), 64'h07);
    repeat (3) cyc(6'b0, 1'b0, 32'h0);
    chk("wd_sticky", 64'(stall_timeout), 64'd1);
    do_reset();
    #1;
    chk("wd_cleared", 64'(stall_timeout), 64'd0);

    // Perf counts, then reset asserted mid-refill
    repeat (5) cyc(6'b000010, 1'b0, 32'h0);
    cyc(6'b0, 1'b1, 32'h55);
    cyc(6'b0, 1'b0, 32'h0);
`ifdef CTRL_PERF_EN
    chk("perf_stall5", 64'(perf_stall_cyc), 64'd5);
    chk("perf_flush1", 64'(perf_flush_cnt), 64'd1);
`endif
    chk("mid_refill", 64'(refill), 64'd1);
    stall_req = 6'b001000;
    #2;
    rst = 1'b0;
    #1;
    chk("arst_refill", 64'(refill), 64'd0);
    chk("arst_flush", 64'(flush), 64'd0);
    chk("arst_new_pc", 64'(new_pc), 64'd0);
    chk("arst_stall", 64'(stall), 64'd0);
`ifdef CTRL_PERF_EN
    chk("arst_perf_stall", 64'(perf_stall_cyc), 64'd0);
    chk("arst_perf_flush", 64'(perf_flush_cnt), 64'd0);
`endif
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    cyc(6'b0, 1'b0, 32'h0);

    // Random run against the model
    for (int n = 0; n < 400; n++) begin
      logic [5:0] sr;
      logic       fr;
      sr = 6'($urandom);
      fr = ($urandom_range(0, 7) == 0);
      cyc(sr, fr, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Parametrised successor to the pipeline stall controller. Merges per-stage stall requests into the stall bus using a highest-stage-wins rule.
- Adds a registered flush/redirect path with a short refill blanking window, and a stall watchdog.
- Sits beside the IF/ID/EX/MEM/WB pipeline. Drives stall to every stage register, and flush/new_pc to the PC and stage registers.

Parameters:
- STAGES, 6, width of stall bus; bit 0 = PC hold, bit k = pipeline stage k paused (k=1..STAGES-1).
- PC_W, 32, width of redirect PC.
- REFILL_CYC, 2, cycles after a flush during which stall requests are ignored (≥1).
- WDOG_W, 8, width of consecutive-stall watchdog counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall_req  in  STAGES  bit k=1: stage k requests stall; bit 0 unused (ignored).
- flush_req  in  1  redirect request (branch mispredict/exception), one-cycle or held.
- flush_pc  in  PC_W  target PC, sampled with flush_req.
- stall  out  STAGES  combinational stall bus.
- flush  out  1  registered; squash all stage registers this cycle.
- new_pc  out  PC_W  registered redirect PC, valid while flush=1.
- refill  out  1  high during REFILL blanking window.
- stall_timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset (rst=0, async): state=IDLE, flush=0, new_pc=0, refill=0, stall_timeout=0, refill and watchdog counters=0. stall is forced to 0 while in reset.
- Stall merge (combinational, same cycle):
  - Let k = highest set index of stall_req[STAGES-1:1].
  - stall = bits k..0 set, all higher bits clear.
  - No request gives stall = 0.
  - Example (STAGES=6): req bit3 → 6'b001111; bits 2 and 3 → 6'b001111; bit2 only → 6'b000111.
- FSM states:
  - IDLE: stall from merge; flush=0, refill=0.
  - FLUSH: exactly one cycle; flush=1, new_pc=latched PC, stall=0.
  - REFILL: refill=1, stall=0 regardless of stall_req; lasts REFILL_CYC cycles (counter REFILL_CYC-1 down to 0), then IDLE.
- Transitions:
  - flush_req=1 in any state → FLUSH next cycle, with flush_pc captured at that edge (latest request wins).
  - FLUSH → REFILL if flush_req=0.
  - REFILL at count 0 → IDLE.
- Latency: flush_req at edge t → flush=1 and new_pc=flush_pc(t) during cycle t+1. Back-to-back flush_req keeps flush high, with new_pc updating each cycle.
- Simultaneous flush_req and stall_req in IDLE: stall still honoured that cycle; flush follows next cycle with stall=0.
- Watchdog:
  - Counter increments each cycle with stall≠0, clears on any cycle with stall=0; saturates at 2^WDOG_W-1.
  - Reaching max sets stall_timeout. It stays set until reset; stalls are not broken.
- Reset mid-FLUSH/REFILL: immediate return to IDLE, all outputs per reset values.

Optional Feature:
- Macro CTRL_PERF_EN.
- When defined, adds outputs perf_stall_cyc (32) and perf_flush_cnt (32):
  - perf_stall_cyc counts cycles with stall≠0.
  - perf_flush_cnt counts cycles with flush=1.
  - Both saturate at 32'hFFFFFFFF, reset to 0.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then idle, stall_req=0 for 10 cycles → stall=6'b000000, flush=0, refill=0, stall_timeout=0.
- stall_req=6'b001000 for 1 cycle, then 6'b000100 → stall=6'b001111, then 6'b000111 in the same cycles; back to 0 after release.
- flush_req pulse with flush_pc=32'h0000_4000 at edge t (REFILL_CYC=2) → flush=1 and new_pc=32'h4000 in cycle t+1; refill=1 in t+2 and t+3; IDLE at t+4. stall_req=6'b001000 asserted in t+2 gives stall=0.
- flush_req on two consecutive edges with PCs 32'h100 then 32'h200 → flush high for 2 cycles, new_pc 32'h100 then 32'h200; then REFILL.
- Hold stall_req=6'b000100 for 255 cycles (WDOG_W=8) → stall_timeout rises on the cycle the counter hits 255. It stays 1 after release until rst=0.
- With CTRL_PERF_EN: 5 stall cycles plus one flush → perf_stall_cyc=5, perf_flush_cnt=1. Drop rst mid-REFILL → all outputs and counters 0 asynchronously.
